// File: rtl/mc_pi_pkg.sv
// mc_pi_pkg
// Shared definitions for the Monte Carlo pi estimator:
//   - state_t     : run-control FSM states
//   - PIPE_DEPTH  : cycles from beat acceptance to counter update
//   - resultWidth : width of the unsigned Q3.FRAC_W result
package mc_pi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DIV,
    ST_DONE
  } state_t;

  localparam int PIPE_DEPTH = 3;

  // Three integer bits hold the value 4.0, which is the largest possible
  // estimate because hits never exceeds total.
  function automatic int resultWidth(input int fracW);
    return fracW + 3;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// seq_divider
// Restoring divider that produces one quotient bit per clock, MSB first,
// and truncates the result.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start_i      load operands; the first quotient bit is formed on this edge
//   dividend_i   DIVIDEND_W-bit unsigned dividend
//   divisor_i    DIVISOR_W-bit unsigned divisor
//   done_o       one-cycle pulse once quotient_o holds the final value
//   quotient_o   QUOT_W-bit quotient; 0 when the divisor was 0; held until
//                the next start
// Only the low QUOT_W dividend bits are shifted through the divider. The bits
// above them seed the partial remainder, so the caller must guarantee
// (dividend_i >> QUOT_W) < divisor_i. A full divide takes QUOT_W edges
// including the start edge. QUOT_W must be at least 2.
module seq_divider #(
  parameter int DIVIDEND_W = 58,
  parameter int DIVISOR_W  = 32,
  parameter int QUOT_W     = 27
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [DIVIDEND_W-1:0] dividend_i,
  input  logic [DIVISOR_W-1:0]  divisor_i,
  output logic                  done_o,
  output logic [QUOT_W-1:0]     quotient_o
);

  localparam int CNT_W = $clog2(QUOT_W + 1);

  logic [DIVISOR_W-1:0] rem_q;
  logic [QUOT_W-1:0]    low_q;
  logic [QUOT_W-1:0]    quot_q;
  logic [DIVISOR_W-1:0] div_q;
  logic                 divZero_q;
  logic                 busy_q;
  logic                 done_q;
  logic [CNT_W-1:0]     count_q;

  logic [DIVISOR_W-1:0] remIn;
  logic [QUOT_W-1:0]    lowIn;
  logic [DIVISOR_W-1:0] divIn;
  logic [DIVISOR_W:0]   trial;
  logic                 ge;
  logic [DIVISOR_W-1:0] remNext;
  logic [QUOT_W-1:0]    lowNext;
  logic [QUOT_W-1:0]    quotNext;

  // One restoring step. On start the step works on the incoming operands so
  // the start edge already yields the first quotient bit. The remainder
  // always stays below the divisor, so the plain DIVISOR_W-bit difference is
  // exact whenever the trial value is not smaller than the divisor.
  always_comb begin
    remIn    = start_i ? DIVISOR_W'(dividend_i >> QUOT_W) : rem_q;
    lowIn    = start_i ? dividend_i[QUOT_W-1:0] : low_q;
    divIn    = start_i ? divisor_i : div_q;
    trial    = {remIn, lowIn[QUOT_W-1]};
    ge       = (trial >= {1'b0, divIn});
    remNext  = ge ? (trial[DIVISOR_W-1:0] - divIn) : trial[DIVISOR_W-1:0];
    lowNext  = lowIn << 1;
    quotNext = start_i ? QUOT_W'(ge) : {quot_q[QUOT_W-2:0], ge};
  end

  // Operand and iteration registers. count_q holds the number of steps still
  // to run after the current edge; done_q is set on the edge of the last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q     <= '0;
      low_q     <= '0;
      quot_q    <= '0;
      div_q     <= '0;
      divZero_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q     <= remNext;
        low_q     <= lowNext;
        quot_q    <= quotNext;
        div_q     <= divisor_i;
        divZero_q <= (divisor_i == '0);
        busy_q    <= 1'b1;
        count_q   <= CNT_W'(QUOT_W - 1);
      end else if (busy_q) begin
        rem_q   <= remNext;
        low_q   <= lowNext;
        quot_q  <= quotNext;
        count_q <= count_q - 1'b1;
        if (count_q == CNT_W'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o     = done_q;
  assign quotient_o = divZero_q ? '0 : quot_q;

endmodule

// File: rtl/mc_pi_estimator.sv
// mc_pi_estimator
// Multi-lane Monte Carlo pi estimator. Each accepted beat carries LANES
// (x,y) pairs of unsigned COORD_W-bit fractions. Pairs strictly inside the
// unit quarter circle count as hits. Once the programmed budget of samples
// has been taken, pi ~= 4*hits/total is formed by a sequential divider.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, num_samples    run request (IDLE only) and sample budget
//   in_valid, in_ready    coordinate beat handshake
//   in_x, in_y            lane i at bits [i*COORD_W +: COORD_W]
//   busy                  high outside IDLE
//   res_valid, res_ready  result handshake
//   res_pi                floor(4*hits*2^FRAC_W/total), unsigned Q3.FRAC_W
//   res_hits, res_total   final counts
module mc_pi_estimator
  import mc_pi_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int COORD_W = 16,
  parameter int CNT_W   = 32,
  parameter int FRAC_W  = 24
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [CNT_W-1:0]                 num_samples,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES*COORD_W-1:0]         in_x,
  input  logic [LANES*COORD_W-1:0]         in_y,
  output logic                             busy,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [resultWidth(FRAC_W)-1:0]   res_pi,
  output logic [CNT_W-1:0]                 res_hits,
  output logic [CNT_W-1:0]                 res_total
);

  localparam int SQ_W       = 2 * COORD_W;
  localparam int POP_W      = $clog2(LANES + 1);
  localparam int RES_W      = resultWidth(FRAC_W);
  localparam int DIVIDEND_W = CNT_W + FRAC_W + 2;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     budget_q, budget_d;
  logic [CNT_W-1:0]     issued_q, issued_d;
  logic [CNT_W-1:0]     hits_q, total_q;
  logic [RES_W-1:0]     resPi_q, resPi_d;
  logic [CNT_W-1:0]     resHits_q, resHits_d;
  logic [CNT_W-1:0]     resTotal_q, resTotal_d;

  logic [CNT_W-1:0]     remaining;
  logic [CNT_W-1:0]     numEn;
  logic [LANES-1:0]     laneEn;
  logic                 accept;
  logic                 clearCnt;
  logic                 divStart;
  logic                 divDone;
  logic [RES_W-1:0]     divQuot;

  // Bit 0 is the S1 (squares) valid, bit 1 the S2 (popcounts) valid; S3 is
  // the counter update itself and needs no valid of its own.
  logic [PIPE_DEPTH-2:0] pipeValid_q;
  logic [LANES-1:0]      en1_q;
  logic [LANES-1:0]      laneHit;
  logic [POP_W-1:0]      popHit_d, popHit_q;
  logic [POP_W-1:0]      popEn_d, popEn_q;

  // Lanes below the remaining budget are live, so the final partial beat
  // uses only the low lanes.
  always_comb begin
    remaining = budget_q - issued_q;
    numEn     = (remaining >= CNT_W'(LANES)) ? CNT_W'(LANES) : remaining;
    for (int i = 0; i < LANES; i++) begin
      laneEn[i] = (remaining > CNT_W'(i));
    end
  end

  assign in_ready = (state_q == ST_RUN) && (issued_q < budget_q);
  assign accept   = in_valid && in_ready;

  // Per-lane S1 squares and S2 compare. A pair is a hit when
  // x^2 + y^2 < 2^(2*COORD_W), i.e. the carry bit of the sum is clear.
  for (genvar g = 0; g < LANES; g++) begin : gLane
    logic [COORD_W-1:0] xc, yc;
    logic [SQ_W-1:0]    sqX_q, sqY_q;
    logic [SQ_W:0]      sum;

    assign xc = in_x[g*COORD_W +: COORD_W];
    assign yc = in_y[g*COORD_W +: COORD_W];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sqX_q <= '0;
        sqY_q <= '0;
      end else if (accept) begin
        sqX_q <= SQ_W'(xc) * SQ_W'(xc);
        sqY_q <= SQ_W'(yc) * SQ_W'(yc);
      end
    end

    assign sum        = {1'b0, sqX_q} + {1'b0, sqY_q};
    assign laneHit[g] = ~sum[SQ_W];
  end

  // S2 popcounts of masked hits and of enabled lanes.
  always_comb begin
    popHit_d = '0;
    popEn_d  = '0;
    for (int i = 0; i < LANES; i++) begin
      popHit_d = popHit_d + POP_W'(laneHit[i] & en1_q[i]);
      popEn_d  = popEn_d + POP_W'(en1_q[i]);
    end
  end

  // Pipeline valids, lane mask and popcount registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipeValid_q <= '0;
      en1_q       <= '0;
      popHit_q    <= '0;
      popEn_q     <= '0;
    end else begin
      pipeValid_q <= {pipeValid_q[0], accept};
      en1_q       <= accept ? laneEn : '0;
      popHit_q    <= popHit_d;
      popEn_q     <= popEn_d;
    end
  end

  // S3 accumulation; a run start clears the counters before any beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hits_q  <= '0;
      total_q <= '0;
    end else if (clearCnt) begin
      hits_q  <= '0;
      total_q <= '0;
    end else if (pipeValid_q[1]) begin
      hits_q  <= hits_q + CNT_W'(popHit_q);
      total_q <= total_q + CNT_W'(popEn_q);
    end
  end

  // Dividend is hits scaled by 4*2^FRAC_W. Since hits <= total, the part
  // above the quotient bits (hits/2) is always below total.
  seq_divider #(
    .DIVIDEND_W (DIVIDEND_W),
    .DIVISOR_W  (CNT_W),
    .QUOT_W     (RES_W)
  ) uDivider (
    .clk        (clk),
    .rst        (rst),
    .start_i    (divStart),
    .dividend_i ({hits_q, (FRAC_W + 2)'(0)}),
    .divisor_i  (total_q),
    .done_o     (divDone),
    .quotient_o (divQuot)
  );

  // Run-control next state. The divider is started in the last DRAIN cycle,
  // once the counters hold their final values.
  always_comb begin
    state_d    = state_q;
    budget_d   = budget_q;
    issued_d   = issued_q;
    resPi_d    = resPi_q;
    resHits_d  = resHits_q;
    resTotal_d = resTotal_q;
    clearCnt   = 1'b0;
    divStart   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          budget_d = num_samples;
          issued_d = '0;
          clearCnt = 1'b1;
          if (num_samples == '0) begin
            resPi_d    = '0;
            resHits_d  = '0;
            resTotal_d = '0;
            state_d    = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          issued_d = issued_q + numEn;
          if (issued_d == budget_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pipeValid_q == '0) begin
          divStart = 1'b1;
          state_d  = ST_DIV;
        end
      end
      ST_DIV: begin
        if (divDone) begin
          resPi_d    = divQuot;
          resHits_d  = hits_q;
          resTotal_d = total_q;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state, run bookkeeping and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      budget_q   <= '0;
      issued_q   <= '0;
      resPi_q    <= '0;
      resHits_q  <= '0;
      resTotal_q <= '0;
    end else begin
      state_q    <= state_d;
      budget_q   <= budget_d;
      issued_q   <= issued_d;
      resPi_q    <= resPi_d;
      resHits_q  <= resHits_d;
      resTotal_q <= resTotal_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign res_valid = (state_q == ST_DONE);
  assign res_pi    = resPi_q;
  assign res_hits  = resHits_q;
  assign res_total = resTotal_q;

endmodule

// File: tb/tb_mc_pi_estimator.sv
// tb_mc_pi_estimator
// Self-checking bench for mc_pi_estimator (LANES=4, COORD_W=16, CNT_W=32,
// FRAC_W=24). A table of runs with hand-computed results, followed by
// back-pressure and mid-run reset sequences.
module tb_mc_pi_estimator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] num_samples = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_x = '0;
  logic [63:0] in_y = '0;
  logic        busy;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [26:0] res_pi;
  logic [31:0] res_hits;
  logic [31:0] res_total;

  int testsRun = 0;
  int testsFailed = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] budget;
    logic [63:0] x;
    logic [63:0] y;
    int          beats;
    logic [31:0] hits;
    logic [31:0] total;
    logic [26:0] pi;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  mc_pi_estimator #(
    .LANES   (4),
    .COORD_W (16),
    .CNT_W   (32),
    .FRAC_W  (24)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_pi      (res_pi),
    .res_hits    (res_hits),
    .res_total   (res_total)
  );

  // Free-running clock and cycle counter used for latency measurement.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case a wait is never satisfied.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Starts a run, feeds the same beat whenever in_ready is high, and waits
  // (bounded) for res_valid. lat counts clock edges from the last accepting
  // edge to the first cycle with res_valid high.
  task automatic applyStimulus(input logic [31:0] budget, input logic [63:0] xv,
                               input logic [63:0] yv, output int beats,
                               output int lat, output bit gotResult);
    int lastAccept;
    beats      = 0;
    lat        = 0;
    gotResult  = 1'b0;
    lastAccept = 0;
    @(negedge clk);
    start       = 1'b1;
    num_samples = budget;
    in_x        = xv;
    in_y        = yv;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (res_valid) begin
        gotResult = 1'b1;
        lat       = (beats > 0) ? (cyc - lastAccept) : 0;
        break;
      end
      in_valid = in_ready;
      if (in_ready) begin
        beats++;
        lastAccept = cyc + 1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    int  beats;
    int  lat;
    bit  got;
    int  seenValid;

    // Runs with hand-computed results; lanes packed {l3,l2,l1,l0}.
    vecs[0] = '{32'd8, 64'h0, 64'h0, 2, 32'd8, 32'd8, 27'h4000000, 30};
    vecs[1] = '{32'd4, {16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000},
                {16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000},
                1, 32'd2, 32'd4, 27'h2000000, 30};
    vecs[2] = '{32'd2, {16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF},
                {16'h0000, 16'h0000, 16'h0200, 16'h0000},
                1, 32'd1, 32'd2, 27'h2000000, 30};
    vecs[3] = '{32'd3, {16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000},
                {16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000},
                1, 32'd1, 32'd3, 27'h1555555, 30};
    vecs[4] = '{32'd0, 64'h0, 64'h0, 0, 32'd0, 32'd0, 27'h0, 0};
    vecs[5] = '{32'd5, 64'h0, 64'h0, 2, 32'd5, 32'd5, 27'h4000000, 30};
    vecs[6] = '{32'd7, {16'hC000, 16'h8000, 16'hC000, 16'h8000},
                {16'hC000, 16'h8000, 16'hC000, 16'h8000},
                2, 32'd4, 32'd7, 27'h2492492, 30};

    repeat (3) @(negedge clk);
    checkOutput("reset in_ready", 64'(in_ready), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset res_valid", 64'(res_valid), 64'd0);
    checkOutput("reset res_pi", 64'(res_pi), 64'd0);
    checkOutput("reset res_hits", 64'(res_hits), 64'd0);
    checkOutput("reset res_total", 64'(res_total), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].budget, vecs[i].x, vecs[i].y, beats, lat, got);
      checkOutput($sformatf("vec%0d result", i), 64'(got), 64'd1);
      checkOutput($sformatf("vec%0d beats", i), 64'(beats), 64'(vecs[i].beats));
      checkOutput($sformatf("vec%0d hits", i), 64'(res_hits), 64'(vecs[i].hits));
      checkOutput($sformatf("vec%0d total", i), 64'(res_total), 64'(vecs[i].total));
      checkOutput($sformatf("vec%0d pi", i), 64'(res_pi), 64'(vecs[i].pi));
      if (vecs[i].lat != 0) begin
        checkOutput($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      checkOutput($sformatf("vec%0d valid drop", i), 64'(res_valid), 64'd0);
      checkOutput($sformatf("vec%0d idle", i), 64'(busy), 64'd0);
      checkOutput($sformatf("vec%0d pi held", i), 64'(res_pi), 64'(vecs[i].pi));
    end

    // Back-pressure: result held for 10 cycles while a start pulse arrives
    // during DONE and must be ignored.
    applyStimulus(vecs[1].budget, vecs[1].x, vecs[1].y, beats, lat, got);
    checkOutput("bp result", 64'(got), 64'd1);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        start       = 1'b1;
        num_samples = 32'd8;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      checkOutput($sformatf("bp valid c%0d", c), 64'(res_valid), 64'd1);
      checkOutput($sformatf("bp pi c%0d", c), 64'(res_pi), 64'h2000000);
      checkOutput($sformatf("bp hits c%0d", c), 64'(res_hits), 64'd2);
    end
    start     = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp idle after ack", 64'(busy), 64'd0);
    checkOutput("bp no run after ack", 64'(in_ready), 64'd0);

    // Reset in the middle of a run: everything drops at once and no result
    // follows.
    @(negedge clk);
    start       = 1'b1;
    num_samples = 32'd8;
    in_x        = '0;
    in_y        = '0;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("mid-run busy", 64'(busy), 64'd1);
    checkOutput("mid-run in_ready", 64'(in_ready), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst in_ready", 64'(in_ready), 64'd0);
    checkOutput("rst busy", 64'(busy), 64'd0);
    checkOutput("rst res_valid", 64'(res_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seenValid = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (res_valid) seenValid++;
    end
    checkOutput("rst no result", 64'(seenValid), 64'd0);

    applyStimulus(32'd8, 64'h0, 64'h0, beats, lat, got);
    checkOutput("post-rst result", 64'(got), 64'd1);
    checkOutput("post-rst hits", 64'(res_hits), 64'd8);
    checkOutput("post-rst total", 64'(res_total), 64'd8);
    checkOutput("post-rst pi", 64'(res_pi), 64'h4000000);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
